// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: turns cache misses, load-use hazards and taken
// branches into per-cycle PC/IF/ID enables, flushes, stall and redirect.
//
//   state | meaning
//   RUN   | normal issue; hazards resolved combinationally each cycle
//   DMISS | D-cache refill in progress; whole pipeline frozen
//   IMISS | I-cache refill in progress; nops fed into ID while older work drains
module pipe_hazard_ctrl #(
  parameter int pc_size  = 32,
  parameter int reg_addr = 5,
  parameter int cnt_size = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [reg_addr-1:0] ID_Rs,
  input  logic [reg_addr-1:0] ID_Rt,
  input  logic                EX_MemRead,
  input  logic [reg_addr-1:0] EX_Rt,
  input  logic                branch_taken,
  input  logic [pc_size-1:0]  branch_target,
  input  logic                icache_miss,
  input  logic                icache_ready,
  input  logic                dcache_miss,
  input  logic                dcache_ready,
  output logic                PC_Write,
  output logic                IF_Write,
  output logic                IF_Flush,
  output logic                ID_Flush,
  output logic                stall,
  output logic                redirect_valid,
  output logic [pc_size-1:0]  redirect_pc,
  output logic [cnt_size-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, DMISS, IMISS} state_t;

  state_t              state_q, state_d;
  logic                redir_pend_q, redir_pend_d;
  logic [pc_size-1:0]  tgt_q, tgt_d;
  logic [cnt_size-1:0] stall_cnt_q;

  logic               pc_write, if_write, if_flush, id_flush, stall_c, redir_v;
  logic [pc_size-1:0] redir_pc;
  logic               load_use;

  assign load_use = EX_MemRead && (EX_Rt != '0) && ((EX_Rt == ID_Rs) || (EX_Rt == ID_Rt));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RUN;
      redir_pend_q <= 1'b0;
      tgt_q        <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      redir_pend_q <= redir_pend_d;
      tgt_q        <= tgt_d;
      if (!pc_write && (stall_cnt_q != {cnt_size{1'b1}}))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    redir_pend_d = redir_pend_q;
    tgt_d        = tgt_q;
    pc_write     = 1'b1;
    if_write     = 1'b1;
    if_flush     = 1'b0;
    id_flush     = 1'b0;
    stall_c      = 1'b0;
    redir_v      = 1'b0;
    redir_pc     = '0;

    case (state_q)
      RUN: begin
        // D-miss outranks everything: EX is frozen, so a branch there re-presents later
        if (dcache_miss && !dcache_ready) begin
          stall_c  = 1'b1;
          pc_write = 1'b0;
          if_write = 1'b0;
          state_d  = DMISS;
        end else if (load_use) begin
          pc_write = 1'b0;
          if_write = 1'b0;
          id_flush = 1'b1;
        end else if (branch_taken) begin
          redir_v  = 1'b1;
          redir_pc = branch_target;
          if_flush = 1'b1;
          id_flush = 1'b1;
        end else if (icache_miss && !icache_ready) begin
          pc_write = 1'b0;
          if_flush = 1'b1;
          state_d  = IMISS;
        end
      end

      DMISS: begin
        if (!dcache_ready) begin
          stall_c  = 1'b1;
          pc_write = 1'b0;
          if_write = 1'b0;
        end else begin
          state_d = RUN;
        end
      end

      IMISS: begin
        pc_write = 1'b0;
        if_flush = 1'b1;
        if (icache_ready) begin
          pc_write     = 1'b1;
          state_d      = RUN;
          redir_pend_d = 1'b0;
          if (branch_taken) begin
            redir_v  = 1'b1;
            redir_pc = branch_target;
          end else if (redir_pend_q) begin
            redir_v  = 1'b1;
            redir_pc = tgt_q;
          end else begin
            if_flush = 1'b0;
          end
        end else if (branch_taken) begin
          tgt_d        = branch_target;
          redir_pend_d = 1'b1;
          id_flush     = 1'b1;
        end
      end

      default: state_d = RUN;
    endcase

    // Hold outputs at their idle values for the whole reset cycle
    if (!rst) begin
      pc_write = 1'b1;
      if_write = 1'b1;
      if_flush = 1'b0;
      id_flush = 1'b0;
      stall_c  = 1'b0;
      redir_v  = 1'b0;
      redir_pc = '0;
    end
  end

  assign PC_Write       = pc_write;
  assign IF_Write       = if_write;
  assign IF_Flush       = if_flush;
  assign ID_Flush       = id_flush;
  assign stall          = stall_c;
  assign redirect_valid = redir_v;
  assign redirect_pc    = redir_pc;
  assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; inputs change just after posedge,
// outputs are checked on the following negedge.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rt;
  logic        EX_MemRead, branch_taken, icache_miss, icache_ready, dcache_miss, dcache_ready;
  logic [31:0] branch_target;
  logic        PC_Write, IF_Write, IF_Flush, ID_Flush, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] stall_cnt;
  logic [5:0]  ctl;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .EX_MemRead(EX_MemRead),
    .EX_Rt(EX_Rt), .branch_taken(branch_taken), .branch_target(branch_target),
    .icache_miss(icache_miss), .icache_ready(icache_ready), .dcache_miss(dcache_miss),
    .dcache_ready(dcache_ready), .PC_Write(PC_Write), .IF_Write(IF_Write),
    .IF_Flush(IF_Flush), .ID_Flush(ID_Flush), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_cnt(stall_cnt)
  );

  // {PC_Write, IF_Write, IF_Flush, ID_Flush, stall, redirect_valid}
  assign ctl = {PC_Write, IF_Write, IF_Flush, ID_Flush, stall, redirect_valid};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ID_Rs = '0; ID_Rt = '0; EX_Rt = '0; EX_MemRead = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    icache_miss = 1'b0; icache_ready = 1'b0;
    dcache_miss = 1'b0; dcache_ready = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle();

    // reset
    cyc(); neg(); chk("rst_ctl", {26'd0, ctl}, 32'b110000);
    cyc(); neg(); chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);
    rst = 1'b1;
    neg();
    chk("post_rst_ctl", {26'd0, ctl}, 32'b110000);
    chk("post_rst_rpc", redirect_pc, 32'd0);
    chk("post_rst_cnt", {16'd0, stall_cnt}, 32'd0);

    // load-use
    cyc(); EX_MemRead = 1'b1; EX_Rt = 5'd5; ID_Rs = 5'd5;
    neg(); chk("lu_rs", {26'd0, ctl}, 32'b000100);
    cyc(); idle();
    neg(); chk("lu_rs_end", {26'd0, ctl}, 32'b110000);
    chk("lu_rs_cnt", {16'd0, stall_cnt}, 32'd1);
    cyc(); EX_MemRead = 1'b1; EX_Rt = 5'd0; ID_Rs = 5'd0;
    neg(); chk("lu_r0", {26'd0, ctl}, 32'b110000);
    cyc(); idle(); EX_MemRead = 1'b1; EX_Rt = 5'd7; ID_Rt = 5'd7; ID_Rs = 5'd3;
    neg(); chk("lu_rt", {26'd0, ctl}, 32'b000100);
    cyc(); idle(); EX_Rt = 5'd7; ID_Rs = 5'd7;
    neg(); chk("lu_noload", {26'd0, ctl}, 32'b110000);
    cyc(); idle();
    neg(); chk("lu_cnt", {16'd0, stall_cnt}, 32'd2);

    // D-miss for 4 cycles with a branch pulse that must be ignored
    do_reset();
    dcache_miss = 1'b1;
    neg(); chk("dm_c10", {26'd0, ctl}, 32'b000010);
    cyc(); dcache_miss = 1'b0;
    neg(); chk("dm_c11", {26'd0, ctl}, 32'b000010);
    cyc(); branch_taken = 1'b1; branch_target = 32'h123;
    neg(); chk("dm_c12_br", {26'd0, ctl}, 32'b000010);
    cyc(); branch_taken = 1'b0;
    neg(); chk("dm_c13", {26'd0, ctl}, 32'b000010);
    cyc(); dcache_ready = 1'b1;
    neg(); chk("dm_c14_rdy", {26'd0, ctl}, 32'b110000);
    cyc(); idle();
    neg(); chk("dm_after", {26'd0, ctl}, 32'b110000);
    chk("dm_cnt", {16'd0, stall_cnt}, 32'd4);

    // I-miss with branch during refill -> redirect on exit
    do_reset();
    icache_miss = 1'b1;
    neg(); chk("im_c20", {26'd0, ctl}, 32'b011000);
    cyc(); icache_miss = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
    neg(); chk("im_c21_br", {26'd0, ctl}, 32'b011100);
    for (int i = 22; i < 25; i++) begin
      cyc(); idle();
      neg(); chk($sformatf("im_c%0d", i), {26'd0, ctl}, 32'b011000);
    end
    cyc(); icache_ready = 1'b1;
    neg(); chk("im_c25_ctl", {26'd0, ctl}, 32'b111001);
    chk("im_c25_rpc", redirect_pc, 32'h40);
    cyc(); idle();
    neg(); chk("im_after", {26'd0, ctl}, 32'b110000);
    chk("im_cnt", {16'd0, stall_cnt}, 32'd5);

    // I-miss without pending redirect: fetched word kept
    cyc(); icache_miss = 1'b1;
    cyc(); idle(); icache_ready = 1'b1;
    neg(); chk("im_plain_exit", {26'd0, ctl}, 32'b110000);

    // I-miss, branch and ready in the same cycle -> direct target
    cyc(); idle(); icache_miss = 1'b1;
    cyc(); idle(); icache_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    neg(); chk("im_bypass_ctl", {26'd0, ctl}, 32'b111001);
    chk("im_bypass_rpc", redirect_pc, 32'h80);

    // Two branches during refill: later target wins
    cyc(); idle(); icache_miss = 1'b1;
    cyc(); idle(); branch_taken = 1'b1; branch_target = 32'h200;
    cyc(); idle(); branch_taken = 1'b1; branch_target = 32'h300;
    cyc(); idle(); icache_ready = 1'b1;
    neg(); chk("im_overwrite_rpc", redirect_pc, 32'h300);

    // Load-use + branch + I-miss in one cycle: bubble only
    cyc(); idle();
    EX_MemRead = 1'b1; EX_Rt = 5'd9; ID_Rs = 5'd9;
    branch_taken = 1'b1; branch_target = 32'h100; icache_miss = 1'b1;
    neg(); chk("prio_lu_ctl", {26'd0, ctl}, 32'b000100);
    cyc(); idle();
    neg(); chk("prio_lu_next", {26'd0, ctl}, 32'b110000);

    // Branch + I-miss without load-use: branch wins
    cyc(); branch_taken = 1'b1; branch_target = 32'h100; icache_miss = 1'b1;
    neg(); chk("prio_br_ctl", {26'd0, ctl}, 32'b111101);
    chk("prio_br_rpc", redirect_pc, 32'h100);
    cyc(); idle();
    neg(); chk("prio_br_next", {26'd0, ctl}, 32'b110000);

    // Counter saturation across 2^16+3 stalled cycles
    do_reset();
    dcache_miss = 1'b1;
    cyc(); dcache_miss = 1'b0;
    for (int i = 0; i < 65538; i++) cyc();
    neg(); chk("sat_cnt", {16'd0, stall_cnt}, 32'hFFFF);
    chk("sat_ctl", {26'd0, ctl}, 32'b000010);
    cyc(); dcache_ready = 1'b1;
    cyc(); idle();
    neg(); chk("sat_hold", {16'd0, stall_cnt}, 32'hFFFF);

    // Reset mid-IMISS with pending redirect
    cyc(); icache_miss = 1'b1;
    cyc(); idle(); branch_taken = 1'b1; branch_target = 32'h44;
    cyc(); idle(); rst = 1'b0;
    neg(); chk("rst_im_ctl", {26'd0, ctl}, 32'b110000);
    cyc(); rst = 1'b1; icache_ready = 1'b1;
    neg(); chk("rst_im_after_ctl", {26'd0, ctl}, 32'b110000);
    chk("rst_im_after_rpc", redirect_pc, 32'd0);
    chk("rst_im_cnt", {16'd0, stall_cnt}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
